muldiv4_exerciser: RTL and testbench

MULDIV4_EXERCISER -- requirements
Module: muldiv4_exerciser

---
 rtl/muldiv4_exerciser_if.sv | 10 +
 rtl/muldiv4_exerciser.sv | 228 ++++++++++++++++++++++
 tb/tb_muldiv4_exerciser.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv4_exerciser_if.sv
// Operand/result bus between the exerciser and the 4-bit multiply/divide unit it drives.
interface muldiv4_exerciser_if;
   logic [7:0] dut_ui;
   logic [7:0] dut_uio;
   logic [7:0] dut_uo;
   logic [1:0] dut_flags;

   modport master (output dut_ui, dut_uio, input  dut_uo, dut_flags);
   modport slave  (input  dut_ui, dut_uio, output dut_uo, dut_flags);
endinterface

// File: rtl/muldiv4_exerciser.sv
// Exhaustive 256-vector exerciser for a 4-bit multiply/divide unit: drives every operand
// pair, computes the reference result bit-serially, and counts/captures mismatches.
module muldiv4_exerciser #(
   parameter int unsigned SETTLE = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                mode_signed,
   input  logic                mode_div,
   muldiv4_exerciser_if.master bus,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [7:0]          err_count,
   output logic                fail_valid,
   output logic [3:0]          fail_a,
   output logic [3:0]          fail_b
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_CALC  = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_CHECK = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [2:0] state_q, state_d;
   logic [7:0] idx_q, idx_d;
   logic       sgn_q, sgn_d;
   logic       div_q, div_d;
   logic [3:0] mag_a_q, mag_a_d;
   logic [3:0] mag_b_q, mag_b_d;
   logic       res_neg_q, res_neg_d;
   logic       rem_neg_q, rem_neg_d;
   logic [1:0] step_q, step_d;
   logic [7:0] prod_q, prod_d;
   logic [3:0] rem_q, rem_d;
   logic [3:0] quo_q, quo_d;
   logic [7:0] exp_uo_q, exp_uo_d;
   logic [1:0] exp_flags_q, exp_flags_d;
   logic [3:0] wait_q, wait_d;
   logic [7:0] err_q, err_d;
   logic       fail_valid_q, fail_valid_d;
   logic [3:0] fail_a_q, fail_a_d;
   logic [3:0] fail_b_q, fail_b_d;

   logic [3:0] op_a, op_b;
   logic [1:0] div_bit;
   logic [4:0] rem_shift, rem_sub;
   logic       rem_fits;
   logic [3:0] quo_next;
   logic [7:0] prod_next;
   logic       mismatch;

   assign op_a = idx_q[3:0];
   assign op_b = idx_q[7:4];

   // One iteration of restoring division (MSB first) and of shift-add multiply (LSB first).
   always_comb begin
      div_bit   = 2'd3 - step_q;
      rem_shift = {rem_q, mag_a_q[div_bit]};
      rem_fits  = (rem_shift >= {1'b0, mag_b_q});
      rem_sub   = rem_fits ? (rem_shift - {1'b0, mag_b_q}) : rem_shift;
      quo_next  = {quo_q[2:0], rem_fits};
      prod_next = prod_q + (mag_b_q[step_q] ? ({4'd0, mag_a_q} << step_q) : 8'd0);
      mismatch  = (bus.dut_flags != exp_flags_q) ||
                  ((exp_flags_q == 2'b00) && (bus.dut_uo != exp_uo_q));
   end

   always_comb begin
      // NOTE: every next-state signal gets a default first, so no path through the case infers a latch.
      state_d      = state_q;
      idx_d        = idx_q;
      sgn_d        = sgn_q;
      div_d        = div_q;
      mag_a_d      = mag_a_q;
      mag_b_d      = mag_b_q;
      res_neg_d    = res_neg_q;
      rem_neg_d    = rem_neg_q;
      step_d       = step_q;
      prod_d       = prod_q;
      rem_d        = rem_q;
      quo_d        = quo_q;
      exp_uo_d     = exp_uo_q;
      exp_flags_d  = exp_flags_q;
      wait_d       = wait_q;
      err_d        = err_q;
      fail_valid_d = fail_valid_q;
      fail_a_d     = fail_a_q;
      fail_b_d     = fail_b_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               sgn_d        = mode_signed;
               div_d        = mode_div;
               err_d        = 8'd0;
               fail_valid_d = 1'b0;
               fail_a_d     = 4'd0;
               fail_b_d     = 4'd0;
               idx_d        = 8'd0;
               state_d      = S_LOAD;
            end
         end

         S_LOAD: begin
            mag_a_d     = (sgn_q && op_a[3]) ? (~op_a + 4'd1) : op_a;
            mag_b_d     = (sgn_q && op_b[3]) ? (~op_b + 4'd1) : op_b;
            res_neg_d   = sgn_q && (op_a[3] ^ op_b[3]);
            rem_neg_d   = sgn_q && op_a[3];
            exp_flags_d = {div_q && (op_b == 4'd0),
                           div_q && sgn_q && (op_a == 4'h8) && (op_b == 4'hF)};
            prod_d      = 8'd0;
            rem_d       = 4'd0;
            quo_d       = 4'd0;
            step_d      = 2'd0;
            state_d     = S_CALC;
         end

         S_CALC: begin
            prod_d = prod_next;
            rem_d  = rem_sub[3:0];
            quo_d  = quo_next;
            step_d = step_q + 2'd1;
            if (step_q == 2'd3) begin
               // Magnitudes are done; apply the signs while storing the final expectation.
               if (div_q) begin
                  exp_uo_d[3:0] = res_neg_q ? (~quo_next + 4'd1) : quo_next;
                  exp_uo_d[7:4] = rem_neg_q ? (~rem_sub[3:0] + 4'd1) : rem_sub[3:0];
               end else begin
                  exp_uo_d = res_neg_q ? (~prod_next + 8'd1) : prod_next;
               end
               wait_d  = 4'(SETTLE - 1);
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            if (wait_q == 4'd0) begin
               state_d = S_CHECK;
            end else begin
               wait_d = wait_q - 4'd1;
            end
         end

         S_CHECK: begin
            if (mismatch) begin
               if (err_q != 8'hFF) begin
                  err_d = err_q + 8'd1;
               end
               if (!fail_valid_q) begin
                  fail_valid_d = 1'b1;
                  fail_a_d     = op_a;
                  fail_b_d     = op_b;
               end
            end
            if (idx_q == 8'hFF) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + 8'd1;
               state_d = S_LOAD;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         idx_q        <= 8'd0;
         sgn_q        <= 1'b0;
         div_q        <= 1'b0;
         mag_a_q      <= 4'd0;
         mag_b_q      <= 4'd0;
         res_neg_q    <= 1'b0;
         rem_neg_q    <= 1'b0;
         step_q       <= 2'd0;
         prod_q       <= 8'd0;
         rem_q        <= 4'd0;
         quo_q        <= 4'd0;
         exp_uo_q     <= 8'd0;
         exp_flags_q  <= 2'd0;
         wait_q       <= 4'd0;
         err_q        <= 8'd0;
         fail_valid_q <= 1'b0;
         fail_a_q     <= 4'd0;
         fail_b_q     <= 4'd0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         sgn_q        <= sgn_d;
         div_q        <= div_d;
         mag_a_q      <= mag_a_d;
         mag_b_q      <= mag_b_d;
         res_neg_q    <= res_neg_d;
         rem_neg_q    <= rem_neg_d;
         step_q       <= step_d;
         prod_q       <= prod_d;
         rem_q        <= rem_d;
         quo_q        <= quo_d;
         exp_uo_q     <= exp_uo_d;
         exp_flags_q  <= exp_flags_d;
         wait_q       <= wait_d;
         err_q        <= err_d;
         fail_valid_q <= fail_valid_d;
         fail_a_q     <= fail_a_d;
         fail_b_q     <= fail_b_d;
      end
   end

   // The vector index only moves on LOAD entry, so it doubles as the operand drive.
   assign bus.dut_ui  = idx_q;
   assign bus.dut_uio = {div_q, sgn_q, 6'd0};

   assign busy       = (state_q == S_LOAD) || (state_q == S_CALC) ||
                       (state_q == S_WAIT) || (state_q == S_CHECK);
   assign done       = (state_q == S_DONE);
   assign pass       = done && (err_q == 8'd0);
   assign err_count  = err_q;
   assign fail_valid = fail_valid_q;
   assign fail_a     = fail_a_q;
   assign fail_b     = fail_b_q;

endmodule

// File: tb/tb_muldiv4_exerciser.sv
// Scoreboard bench: a behavioural (optionally faulty) multiply/divide unit feeds the exerciser,
// and each sweep's expected summary is predicted from plain integer arithmetic.
module tb_muldiv4_exerciser;

   localparam int unsigned SETTLE = 2;
   localparam int SWEEP_CYCLES    = 256 * (6 + SETTLE);
   localparam int BUDGET          = SWEEP_CYCLES + 64;

   typedef enum int {F_NONE, F_QUO, F_EDIV0, F_EOVER0, F_STUCK0, F_RANDOM} fault_e;

   typedef struct {
      logic [7:0] err;
      logic       fv;
      logic [3:0] fa;
      logic [3:0] fb;
      logic       pass;
      int         cycles;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       mode_signed = 1'b0;
   logic       mode_div = 1'b0;
   logic       busy, done, pass, fail_valid;
   logic [7:0] err_count;
   logic [3:0] fail_a, fail_b;

   fault_e     fault_kind = F_NONE;
   logic [3:0] fault_a = 4'd0;
   logic [3:0] fault_b = 4'd0;
   logic [7:0] bad_mask [256];

   int   tests = 0;
   int   fails = 0;
   int   checked_cnt = 0;
   int   cyc = 0;
   int   t0 = 0;
   exp_t exp_q[$];
   exp_t mon_e;
   logic busy_prev = 1'b0;
   logic done_prev = 1'b0;

   muldiv4_exerciser_if bus();

   muldiv4_exerciser #(.SETTLE(SETTLE)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .mode_signed (mode_signed),
      .mode_div    (mode_div),
      .bus         (bus),
      .busy        (busy),
      .done        (done),
      .pass        (pass),
      .err_count   (err_count),
      .fail_valid  (fail_valid),
      .fail_a      (fail_a),
      .fail_b      (fail_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Correct unit: {ediv0, eover, uo}; q/r content is arbitrary whenever a flag is raised.
   function automatic logic [9:0] ideal(input logic [7:0] ui, input logic sgn, input logic div);
      int a, b;
      logic [1:0] flags;
      logic [7:0] uo;
      if (sgn) begin
         a = int'($signed(ui[3:0]));
         b = int'($signed(ui[7:4]));
      end else begin
         a = int'(ui[3:0]);
         b = int'(ui[7:4]);
      end
      flags = 2'b00;
      if (!div) begin
         uo = 8'(a * b);
      end else if (b == 0) begin
         flags = 2'b10;
         uo    = 8'hEE;
      end else if (a == -8 && b == -1) begin
         flags = 2'b01;
         uo    = 8'h80;
      end else begin
         uo = {4'(a % b), 4'(a / b)};
      end
      return {flags, uo};
   endfunction

   function automatic logic [9:0] dut_model(input logic [7:0] ui, input logic [7:0] uio,
                                            input fault_e kind, input logic [3:0] fa,
                                            input logic [3:0] fb, input logic [7:0] mask);
      logic [9:0] r;
      r = ideal(ui, uio[6], uio[7]);
      case (kind)
         F_QUO:    if (ui[3:0] == fa && ui[7:4] == fb) r[3:0] = r[3:0] ^ 4'h1;
         F_EDIV0: begin
            if (ui[7:4] == 4'd0) r[7:0] = 8'h5A ^ ui;
            if (ui[3:0] == 4'd5 && ui[7:4] == 4'd0) r[9] = 1'b0;
         end
         F_EOVER0: r[8] = 1'b0;
         F_STUCK0: r[7:0] = 8'h00;
         F_RANDOM: r[7:0] = r[7:0] ^ mask;
         default:  r = r;
      endcase
      return r;
   endfunction

   assign {bus.dut_flags, bus.dut_uo} = dut_model(bus.dut_ui, bus.dut_uio, fault_kind,
                                                  fault_a, fault_b, bad_mask[bus.dut_ui]);

   function automatic exp_t predict(input logic sgn, input logic div);
      exp_t e;
      int n;
      logic [7:0] ui;
      logic [9:0] want, got;
      n    = 0;
      e.fv = 1'b0;
      e.fa = 4'd0;
      e.fb = 4'd0;
      for (int i = 0; i < 256; i++) begin
         ui   = 8'(i);
         want = ideal(ui, sgn, div);
         got  = dut_model(ui, {div, sgn, 6'd0}, fault_kind, fault_a, fault_b, bad_mask[i]);
         if (want[9:8] != got[9:8] || (want[9:8] == 2'b00 && want[7:0] != got[7:0])) begin
            n++;
            if (!e.fv) begin
               e.fv = 1'b1;
               e.fa = ui[3:0];
               e.fb = ui[7:4];
            end
         end
      end
      e.err    = (n > 255) ? 8'hFF : 8'(n);
      e.pass   = (n == 0);
      e.cycles = SWEEP_CYCLES;
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Monitor: timestamps each sweep start and scores every completed sweep against the queue.
   always @(negedge clk) begin
      if (!rst) begin
         if (busy && !busy_prev) begin
            t0 = cyc;
            check("sweep_start_cleared", {done, fail_valid, err_count}, 32'd0);
         end
         if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_done: got done=1 expected no sweep pending");
            end else begin
               mon_e = exp_q.pop_front();
               check("sb_err_count",  err_count,  mon_e.err);
               check("sb_fail_valid", fail_valid, mon_e.fv);
               check("sb_fail_a",     fail_a,     mon_e.fa);
               check("sb_fail_b",     fail_b,     mon_e.fb);
               check("sb_pass",       pass,       mon_e.pass);
               check("sb_cycles",     cyc - t0,   mon_e.cycles);
            end
            checked_cnt++;
         end
      end
      busy_prev = busy;
      done_prev = done;
   end

   task automatic wait_checked(input int target);
      int n;
      n = 0;
      while (checked_cnt < target && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      if (checked_cnt < target) begin
         tests++;
         fails++;
         $display("FAIL sweep_timeout: got %0d sweeps expected %0d", checked_cnt, target);
         exp_q.delete();
         checked_cnt = target;
      end
   endtask

   task automatic wait_ui(input logic [7:0] v);
      int n;
      n = 0;
      while (bus.dut_ui !== v && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      check("wait_dut_ui", bus.dut_ui, v);
   endtask

   task automatic run_sweep(input logic sgn, input logic div, input fault_e kind,
                            input logic [3:0] fa, input logic [3:0] fb, input bit poke_start);
      int target;
      fault_kind = kind;
      fault_a    = fa;
      fault_b    = fb;
      exp_q.push_back(predict(sgn, div));
      target = checked_cnt + 1;
      @(negedge clk);
      mode_signed = sgn;
      mode_div    = div;
      start       = 1'b1;
      @(negedge clk);
      start       = 1'b0;
      mode_signed = 1'($urandom);
      mode_div    = 1'($urandom);
      if (poke_start) begin
         repeat (300) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      wait_checked(target);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      exp_t e;
      int   target;
      foreach (bad_mask[i]) bad_mask[i] = 8'h00;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_bus",    {bus.dut_ui, bus.dut_uio, busy, done, pass, fail_valid}, 32'd0);
      check("reset_status", {err_count, fail_a, fail_b}, 32'd0);
      rst = 1'b0;

      // Ideal unit in every mode; start pulsed mid-sweep must be ignored.
      run_sweep(1'b0, 1'b0, F_NONE, 4'd0, 4'd0, 1'b1);
      check("ideal_umul_pass", pass, 32'd1);
      check("ideal_umul_fv",   fail_valid, 32'd0);
      run_sweep(1'b1, 1'b0, F_NONE, 4'd0, 4'd0, 1'b0);
      run_sweep(1'b0, 1'b1, F_NONE, 4'd0, 4'd0, 1'b0);
      run_sweep(1'b1, 1'b1, F_NONE, 4'd0, 4'd0, 1'b0);
      check("ideal_sdiv_err", err_count, 32'd0);

      run_sweep(1'b1, 1'b1, F_QUO, 4'd7, 4'd2, 1'b0);
      check("quo7_2_err",  err_count, 32'd1);
      check("quo7_2_a",    fail_a, 32'd7);
      check("quo7_2_b",    fail_b, 32'd2);
      check("quo7_2_pass", pass, 32'd0);

      run_sweep(1'b0, 1'b1, F_EDIV0, 4'd0, 4'd0, 1'b0);
      check("ediv0_err", err_count, 32'd1);
      check("ediv0_ab",  {fail_a, fail_b}, {24'd0, 4'd5, 4'd0});
      run_sweep(1'b1, 1'b1, F_EDIV0, 4'd0, 4'd0, 1'b0);

      run_sweep(1'b1, 1'b1, F_EOVER0, 4'd0, 4'd0, 1'b0);
      check("eover_s_err", err_count, 32'd1);
      check("eover_s_ab",  {fail_a, fail_b}, {24'd0, 4'd8, 4'd15});
      run_sweep(1'b0, 1'b1, F_EOVER0, 4'd0, 4'd0, 1'b0);
      check("eover_u_err", err_count, 32'd0);

      run_sweep(1'b0, 1'b0, F_STUCK0, 4'd0, 4'd0, 1'b0);
      check("stuck0_err", err_count, 32'd225);
      check("stuck0_ab",  {fail_a, fail_b}, {24'd0, 4'd1, 4'd1});

      // Random sparse result corruption in random modes.
      for (int r = 0; r < 4; r++) begin
         foreach (bad_mask[i]) bad_mask[i] = ($urandom_range(7) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
         run_sweep(1'($urandom), 1'($urandom), F_RANDOM, 4'd0, 4'd0, 1'b0);
      end

      // Every multiply result wrong: 256 mismatches saturate the counter.
      foreach (bad_mask[i]) bad_mask[i] = 8'($urandom_range(255, 1));
      run_sweep(1'($urandom), 1'b0, F_RANDOM, 4'd0, 4'd0, 1'b0);
      check("saturate_err", err_count, 32'd255);
      foreach (bad_mask[i]) bad_mask[i] = 8'h00;

      // Start held across the final CHECK: sweep completes, then restarts from DONE.
      fault_kind = F_NONE;
      e = predict(1'b1, 1'b1);
      exp_q.push_back(e);
      exp_q.push_back(e);
      target = checked_cnt + 2;
      @(negedge clk);
      mode_signed = 1'b1;
      mode_div    = 1'b1;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_ui(8'hFF);
      start = 1'b1;
      wait_checked(target - 1);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check("restart_busy", busy, 32'd1);
      wait_checked(target);

      // Reset in the middle of a failing sweep, then a clean restart.
      fault_kind = F_STUCK0;
      @(negedge clk);
      mode_signed = 1'b0;
      mode_div    = 1'b0;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_ui(8'd100);
      check("pre_reset_err_nonzero", (err_count != 8'd0), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("midrst_bus",    {bus.dut_ui, bus.dut_uio, busy, done, pass, fail_valid}, 32'd0);
      check("midrst_status", {err_count, fail_a, fail_b}, 32'd0);
      @(negedge clk);
      rst        = 1'b0;
      fault_kind = F_NONE;
      exp_q.push_back(predict(1'b0, 1'b0));
      target = checked_cnt + 1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("restart_ui", bus.dut_ui, 32'd0);
      wait_checked(target);
      check("restart_pass", pass, 32'd1);

      repeat (4) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
